// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA raster timing generator and its consumers.
//   - Default 800x600 @ 72 Hz timing (50 MHz pixel rate) and derived totals
//   - Coordinate widths for the horizontal and vertical counters
//   - vga_pix_t: the {disp_enbl, h_coord, v_coord} bundle used by the
//     colour stage
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 56;
  localparam int DEF_H_SYNC   = 120;
  localparam int DEF_H_BP     = 64;

  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_FP     = 37;
  localparam int DEF_V_SYNC   = 6;
  localparam int DEF_V_BP     = 23;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int H_COORD_W = 11;
  localparam int V_COORD_W = 10;

  typedef struct packed {
    logic                 disp_enbl;
    logic [H_COORD_W-1:0] h_coord;
    logic [V_COORD_W-1:0] v_coord;
  } vga_pix_t;

endpackage

// File: rtl/vga_timing_if.sv
// ---------------------------------------------------------------------------
// vga_timing_if
// Bundle between the raster timing generator and the colour stage.
//   i_pix_en      : pixel-rate enable into the generator
//   o_h_coord     : horizontal pixel counter
//   o_v_coord     : vertical line counter
//   o_disp_enbl   : visible-area flag
//   o_hsync       : horizontal sync
//   o_vsync       : vertical sync
//   o_frame_start : one-pixel pulse at (0,0)
//   o_frame_cnt   : frame counter (only with VGA_TIMING_FRAME_CNT_EN)
// Modports: master = timing generator, slave = consumer / pixel-rate source.
// ---------------------------------------------------------------------------
interface vga_timing_if;
  import vga_pkg::*;

  logic                 i_pix_en;
  logic [H_COORD_W-1:0] o_h_coord;
  logic [V_COORD_W-1:0] o_v_coord;
  logic                 o_disp_enbl;
  logic                 o_hsync;
  logic                 o_vsync;
  logic                 o_frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0]           o_frame_cnt;
`endif

  modport master (
    input  i_pix_en,
    output o_h_coord, o_v_coord, o_disp_enbl, o_hsync, o_vsync, o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , output o_frame_cnt
`endif
  );

  modport slave (
    output i_pix_en,
    input  o_h_coord, o_v_coord, o_disp_enbl, o_hsync, o_vsync, o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    , input o_frame_cnt
`endif
  );

endinterface

// File: rtl/vga_timing_axis_cnt.sv
// ---------------------------------------------------------------------------
// vga_axis_cnt
// One raster axis: a modulo-TOTAL counter with enable, plus decode of the
// visible and sync windows. Decode is taken from the value the counter is
// about to load so the parent can register it on the same edge as the count.
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_en           : advance by one on this edge
//   o_cnt          : current count (resets to TOTAL-1)
//   o_wrap         : current count is TOTAL-1
//   o_nxt_active   : next count is inside [0, ACTIVE)
//   o_nxt_sync     : next count is inside [SYNC_START, SYNC_END)
//   o_nxt_zero     : next count is 0
// ---------------------------------------------------------------------------
module vga_axis_cnt #(
  parameter int WIDTH      = 11,
  parameter int TOTAL      = 1040,
  parameter int ACTIVE     = 800,
  parameter int SYNC_START = 856,
  parameter int SYNC_END   = 976
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_wrap,
  output logic             o_nxt_active,
  output logic             o_nxt_sync,
  output logic             o_nxt_zero
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] ACT  = WIDTH'(ACTIVE);
  localparam logic [WIDTH-1:0] SS   = WIDTH'(SYNC_START);
  localparam logic [WIDTH-1:0] SE   = WIDTH'(SYNC_END);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_nxt;

  always_comb begin
    w_nxt = r_cnt;
    if (i_en) begin
      w_nxt = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  // Reset parks the axis on its last position so the first enable lands on 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= LAST;
    end else begin
      r_cnt <= w_nxt;
    end
  end

  assign o_cnt        = r_cnt;
  assign o_wrap       = (r_cnt == LAST);
  assign o_nxt_active = (w_nxt < ACT);
  assign o_nxt_sync   = (w_nxt >= SS) && (w_nxt < SE);
  assign o_nxt_zero   = (w_nxt == '0);

endmodule

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Raster timing generator for the VGA output path. Every output is a flop
// loaded on the same edge, so coordinates, display enable and syncs are
// mutually aligned.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   vif (master) : i_pix_en in; o_h_coord, o_v_coord, o_disp_enbl, o_hsync,
//                  o_vsync, o_frame_start (and o_frame_cnt) out
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds the 8-bit o_frame_cnt.
// ---------------------------------------------------------------------------
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit H_SYNC_POL = 1'b1,
  parameter bit V_SYNC_POL = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  vga_timing_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic                 w_h_wrap;
  logic                 w_h_nxt_active;
  logic                 w_h_nxt_sync;
  logic                 w_h_nxt_zero;
  logic                 w_v_wrap;
  logic                 w_v_nxt_active;
  logic                 w_v_nxt_sync;
  logic                 w_v_nxt_zero;
  logic                 w_v_en;
  logic [H_COORD_W-1:0] w_h_cnt;
  logic [V_COORD_W-1:0] w_v_cnt;

  logic r_disp_enbl;
  logic r_hsync;
  logic r_vsync;
  logic r_frame_start;

  vga_axis_cnt #(
    .WIDTH      (H_COORD_W),
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
  ) u_h_axis (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (vif.i_pix_en),
    .o_cnt        (w_h_cnt),
    .o_wrap       (w_h_wrap),
    .o_nxt_active (w_h_nxt_active),
    .o_nxt_sync   (w_h_nxt_sync),
    .o_nxt_zero   (w_h_nxt_zero)
  );

  // The line counter only steps on the pixel edge that wraps the line.
  assign w_v_en = vif.i_pix_en && w_h_wrap;

  vga_axis_cnt #(
    .WIDTH      (V_COORD_W),
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
  ) u_v_axis (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (w_v_en),
    .o_cnt        (w_v_cnt),
    .o_wrap       (w_v_wrap),
    .o_nxt_active (w_v_nxt_active),
    .o_nxt_sync   (w_v_nxt_sync),
    .o_nxt_zero   (w_v_nxt_zero)
  );

  // Decodes come from next-state counts, so these flops line up with the
  // coordinate flops. With i_pix_en low the next state equals the current
  // state and every flop reloads its own value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_disp_enbl   <= 1'b0;
      r_hsync       <= ~H_SYNC_POL;
      r_vsync       <= ~V_SYNC_POL;
      r_frame_start <= 1'b0;
    end else begin
      r_disp_enbl   <= w_h_nxt_active && w_v_nxt_active;
      r_hsync       <= w_h_nxt_sync ? H_SYNC_POL : ~H_SYNC_POL;
      r_vsync       <= w_v_nxt_sync ? V_SYNC_POL : ~V_SYNC_POL;
      r_frame_start <= w_h_nxt_zero && w_v_nxt_zero;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;

  // Steps on the enabled edge leaving the last pixel, i.e. the edge that
  // raises o_frame_start.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame_cnt <= 8'd0;
    end else if (vif.i_pix_en && w_h_wrap && w_v_wrap) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign vif.o_frame_cnt = r_frame_cnt;
`endif

  assign vif.o_h_coord     = w_h_cnt;
  assign vif.o_v_coord     = w_v_cnt;
  assign vif.o_disp_enbl   = r_disp_enbl;
  assign vif.o_hsync       = r_hsync;
  assign vif.o_vsync       = r_vsync;
  assign vif.o_frame_start = r_frame_start;

endmodule
